// File: rtl/countdown_timer_if.sv
// countdown_timer_if: preset/button inputs and time/status outputs of countdown_timer.
// BCD digit signals exist only when COUNTDOWN_BCD_EN is defined.
interface countdown_timer_if;
  logic       setTime;
  logic [5:0] setSeg;
  logic [5:0] setMin;
  logic       btn_start;
  logic       btn_pause;
  logic [5:0] curSeg;
  logic [5:0] curMin;
  logic       running;
  logic       done;
  logic       alarm;
`ifdef COUNTDOWN_BCD_EN
  logic [3:0] bcdMinT;
  logic [3:0] bcdMinU;
  logic [3:0] bcdSegT;
  logic [3:0] bcdSegU;

  modport master (
    output setTime, setSeg, setMin,
    output btn_start, btn_pause,
    input  curSeg, curMin,
    input  running, done, alarm,
    input  bcdMinT, bcdMinU,
    input  bcdSegT, bcdSegU
  );

  modport slave (
    input  setTime, setSeg, setMin,
    input  btn_start, btn_pause,
    output curSeg, curMin,
    output running, done, alarm,
    output bcdMinT, bcdMinU,
    output bcdSegT, bcdSegU
  );
`else
  modport master (
    output setTime, setSeg, setMin,
    output btn_start, btn_pause,
    input  curSeg, curMin,
    input  running, done, alarm
  );

  modport slave (
    input  setTime, setSeg, setMin,
    input  btn_start, btn_pause,
    output curSeg, curMin,
    output running, done, alarm
  );
`endif
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss countdown with 1 s prescaler, start/pause and alarm.
// COUNTDOWN_BCD_EN adds registered BCD digit outputs.
module countdown_timer #(
  parameter int TICK_DIV  = 50000000,
  parameter int ALARM_CYC = 8
) (
  input  logic          clk,
  input  logic          rst,
  countdown_timer_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_CYC > 1) ? $clog2(ALARM_CYC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] AMAX = AW'(ALARM_CYC - 1);

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [5:0]    cur_s;
  logic [5:0]    cur_m;
  logic [5:0]    dec_s;
  logic [5:0]    dec_m;
  logic [5:0]    pre_s;
  logic [5:0]    pre_m;
  logic          start_q;
  logic          pause_q;
  logic          start_p;
  logic          pause_p;
  logic [PW-1:0] pcnt;
  logic [AW-1:0] acnt;
  logic          pcnt_en;
  logic          tick;
  logic          dec_zero;
  logic          nonzero;
  logic          running_q;
  logic          done_q;
  logic          alarm_q;

  assign start_p = bus.btn_start & ~start_q;
  assign pause_p = bus.btn_pause & ~pause_q;
  assign pre_s   = (bus.setSeg > 6'd59) ? 6'd59 : bus.setSeg;
  assign pre_m   = (bus.setMin > 6'd59) ? 6'd59 : bus.setMin;
  assign nonzero = (cur_s != 6'd0) || (cur_m != 6'd0);

  // prescaler only advances in RUN, or in DONE while the alarm is timing out
  assign pcnt_en = (state == RUN) || ((state == DONE) && alarm_q);
  assign tick    = pcnt_en && (pcnt == PMAX);

  always_comb begin
    dec_s = cur_s;
    dec_m = cur_m;
    if (cur_s != 6'd0) begin
      dec_s = cur_s - 6'd1;
    end else if (cur_m != 6'd0) begin
      dec_s = 6'd59;
      dec_m = cur_m - 6'd1;
    end
  end

  assign dec_zero = (dec_s == 6'd0) && (dec_m == 6'd0);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (!bus.setTime && start_p && nonzero)
          state_n = RUN;
      end
      RUN: begin
        if (bus.setTime)
          state_n = IDLE;
        else if (tick && dec_zero)
          state_n = DONE;
        else if (pause_p)
          state_n = PAUSE;
      end
      PAUSE: begin
        if (bus.setTime)
          state_n = IDLE;
        else if (start_p)
          state_n = RUN;
      end
      DONE: begin
        if (bus.setTime || start_p)
          state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_s     <= 6'd0;
      cur_m     <= 6'd0;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      pcnt      <= '0;
      acnt      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      start_q   <= bus.btn_start;
      pause_q   <= bus.btn_pause;
      state     <= state_n;
      running_q <= (state_n == RUN);
      done_q    <= (state_n == DONE);

      if ((state == IDLE) && (state_n == RUN))
        pcnt <= '0;
      else if (pcnt_en)
        pcnt <= tick ? '0 : pcnt + 1'b1;

      if ((state == IDLE) && bus.setTime) begin
        cur_s <= pre_s;
        cur_m <= pre_m;
      end else if ((state == RUN) && !bus.setTime && tick) begin
        cur_s <= dec_s;
        cur_m <= dec_m;
      end

      if ((state != DONE) && (state_n == DONE)) begin
        alarm_q <= 1'b1;
        acnt    <= '0;
      end else if ((state == DONE) && (state_n != DONE)) begin
        alarm_q <= 1'b0;
      end else if ((state == DONE) && tick) begin
        acnt <= acnt + 1'b1;
        if (acnt == AMAX)
          alarm_q <= 1'b0;
      end
    end
  end

  assign bus.curSeg  = cur_s;
  assign bus.curMin  = cur_m;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.alarm   = alarm_q;

`ifdef COUNTDOWN_BCD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bcdMinT <= 4'd0;
      bus.bcdMinU <= 4'd0;
      bus.bcdSegT <= 4'd0;
      bus.bcdSegU <= 4'd0;
    end else begin
      bus.bcdMinT <= 4'(cur_m / 6'd10);
      bus.bcdMinU <= 4'(cur_m % 6'd10);
      bus.bcdSegT <= 4'(cur_s / 6'd10);
      bus.bcdSegU <= 4'(cur_s % 6'd10);
    end
  end
`endif

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Consumer of the preset minutes/seconds produced by the push-button setting block.
- Loads the preset, counts down once per second, and reports the remaining time and a done/alarm flag to the display and buzzer logic.
- Contains its own 1 s prescaler, start/pause edge detection and a 4-state control FSM.

Parameters:
- TICK_DIV, 50000000, clock cycles per 1 s tick (benches use a small value, e.g. 4).
- ALARM_CYC, 8, number of ticks the alarm output stays asserted after expiry.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- setTime  input  1  level; 1 = setting mode, preset tracked continuously.
- setSeg  input  6  preset seconds, 0..59.
- setMin  input  6  preset minutes, 0..59.
- btn_start  input  1  level, debounced; rising edge = start/resume.
- btn_pause  input  1  level, debounced; rising edge = pause.
- curSeg  output  6  remaining seconds.
- curMin  output  6  remaining minutes.
- running  output  1  1 while in RUN.
- done  output  1  1 while in DONE.
- alarm  output  1  1 for ALARM_CYC ticks after expiry.

Behaviour:
- Reset (async, rst=1): state=IDLE; curSeg=0, curMin=0; running=0, done=0, alarm=0; prescaler=0; edge-detect registers=0.
- Preset clamp: any setSeg or setMin value >59 is loaded as 59.
- Edge detect: one registered copy each of btn_start and btn_pause. A press is current=1 and previous=0. Each press is acted on in the cycle after it is seen; outputs update at that clock edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - tick = (count==TICK_DIV-1). On tick the count wraps to 0.
  - Cleared to 0 on every entry to RUN from IDLE. It is held, not cleared, in PAUSE.
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - While setTime=1: curSeg/curMin follow the clamped preset every cycle.
  - start press with setTime=0 and (curMin,curSeg)!=(0,0): go to RUN.
  - start press with time 00:00: ignored, stay in IDLE.
- RUN:
  - On tick, decrement as mm:ss:
    - seg>0: seg-1.
    - seg==0 and min>0: seg=59, min-1.
  - If that decrement produces 00:00, go to DONE in the same edge.
  - pause press: go to PAUSE.
  - setTime=1: go to IDLE and reload the preset next cycle. This has priority over tick and pause.
- PAUSE:
  - Time frozen.
  - start press: go to RUN.
  - setTime=1: go to IDLE.
- DONE:
  - curMin=0, curSeg=0; done=1.
  - alarm=1 from entry for ALARM_CYC ticks; the prescaler keeps running in DONE for this count only.
  - start press or setTime=1: go to IDLE, clear done and alarm. With setTime=0 the IDLE time stays 00:00.
- Simultaneous events:
  - setTime beats start and pause.
  - In RUN, a tick together with a pause press: apply the decrement first, then enter PAUSE.
  - start and pause pressed in the same cycle: start wins in IDLE/PAUSE, pause wins in RUN.
- running = (state==RUN), registered. done = (state==DONE), registered.
- No wrap below 00:00; the counter never underflows.

Optional Feature:
- Macro: COUNTDOWN_BCD_EN.
- When defined, four extra outputs are added: bcdMinT[3:0], bcdMinU[3:0], bcdSegT[3:0], bcdSegU[3:0].
  - These are the tens/units digits of curMin and curSeg.
  - They are registered and lag curMin/curSeg by exactly 1 cycle.
  - Reset value: 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Load and expire: TICK_DIV=4. setTime=1, setMin=1, setSeg=2, then setTime=0; start press. Expect 01:02 -> 01:01 -> 01:00 -> 00:59 on successive ticks (every 4 cycles), and done=1 exactly 62 ticks after start.
- Clamp and zero-start: setSeg=63, setMin=0 with setTime=1 -> curSeg=59. Preset 00:00 plus start press -> stays IDLE, running=0.
- Pause/resume: at 00:10 press pause -> value held for 20 cycles, prescaler frozen. Press start -> next decrement after the remaining prescaler cycles; reaches 00:09.
- setTime abort: in RUN at 00:40, raise setTime with preset 02:15 -> IDLE, curMin=2, curSeg=15 one cycle later, running=0.
- Alarm length: ALARM_CYC=3 -> alarm high for exactly 12 cycles after done rises. Start press in DONE -> done=0, alarm=0, IDLE at 00:00.
- Async reset mid-RUN: assert rst between clock edges -> all outputs 0 immediately. After release, IDLE and ignores held btn_start until a new rising edge.
